// File: rtl/contador_regressivo_pkg.sv
// Shared definitions for the microwave MM:SS countdown timer:
// state encoding, BCD limits and small BCD/binary conversion helpers.
package contador_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [3:0]  BCD_MAX_DIGIT    = 4'd9;
   localparam logic [3:0]  BCD_MAX_SEC_TENS = 4'd5;
   localparam logic [15:0] TIME_ZERO        = 16'h0000;

   function automatic logic [3:0] satDigit(input logic [3:0] d, input logic [3:0] maxVal);
      return (d > maxVal) ? maxVal : d;
   endfunction

   function automatic logic [6:0] bcd2bin(input logic [7:0] b);
      return 7'(b[7:4]) * 7'd10 + 7'(b[3:0]);
   endfunction

   function automatic logic [7:0] bin2bcd(input logic [6:0] v);
      return {4'(v / 7'd10), 4'(v % 7'd10)};
   endfunction

endpackage

// File: rtl/contador_regressivo_bcd_mmss_dec.sv
// Combinational MM:SS BCD decrement by one second, with borrow chain
// sec_units -> sec_tens (0..5) -> min_units -> min_tens.
module bcd_mmss_dec
   import contador_pkg::*;
(
   input  logic [15:0] time_i,
   output logic [15:0] result_o,
   output logic        zero_o
);

   logic [3:0] minTens, minUnits, secTens, secUnits;

   always_comb begin
      minTens  = time_i[15:12];
      minUnits = time_i[11:8];
      secTens  = time_i[7:4];
      secUnits = time_i[3:0];
      if (secUnits != 4'd0) begin
         secUnits = secUnits - 4'd1;
      end else begin
         secUnits = BCD_MAX_DIGIT;
         if (secTens != 4'd0) begin
            secTens = secTens - 4'd1;
         end else begin
            secTens = BCD_MAX_SEC_TENS;
            if (minUnits != 4'd0) begin
               minUnits = minUnits - 4'd1;
            end else begin
               minUnits = BCD_MAX_DIGIT;
               minTens  = (minTens != 4'd0) ? minTens - 4'd1 : BCD_MAX_DIGIT;
            end
         end
      end
      result_o = {minTens, minUnits, secTens, secUnits};
      zero_o   = (result_o == TIME_ZERO);
   end

endmodule

// File: rtl/contador_regressivo.sv
// Microwave cooking countdown timer: loads MM:SS from the keypad, counts
// down on the 1 Hz enable, supports pause/door interlock and quick-start.
module contador_regressivo
   import contador_pkg::*;
#(
   parameter int          QUICK_SEC = 30,
   parameter logic [15:0] MAX_BCD   = 16'h9959
)(
   input  logic        clk_in,
   input  logic        reset,
   input  logic        tick_1hz,
   input  logic        load,
   input  logic [15:0] load_bcd,
   input  logic        start,
   input  logic        pause,
   input  logic        clear,
   input  logic        door_open,
   output logic [15:0] time_bcd,
   output logic        running,
   output logic        done
);

   state_t      state_q, state_d;
   logic [15:0] time_q, time_d;
   logic        running_q, done_q;

   logic [15:0] decResult;
   logic        decZero;
   logic [15:0] loadSan;
   logic [15:0] quickSum;
   logic [7:0]  secSum, minSum;

   bcd_mmss_dec u_dec (
      .time_i   (time_q),
      .result_o (decResult),
      .zero_o   (decZero)
   );

   assign loadSan = {satDigit(load_bcd[15:12], BCD_MAX_DIGIT),
                     satDigit(load_bcd[11:8],  BCD_MAX_DIGIT),
                     satDigit(load_bcd[7:4],   BCD_MAX_SEC_TENS),
                     satDigit(load_bcd[3:0],   BCD_MAX_DIGIT)};

   // Quick-start add works in binary per field; at most one minute of carry
   // because QUICK_SEC is below 60.
   always_comb begin
      secSum = 8'(bcd2bin(time_q[7:0])) + 8'(QUICK_SEC);
      minSum = 8'(bcd2bin(time_q[15:8]));
      if (secSum >= 8'd60) begin
         secSum = secSum - 8'd60;
         minSum = minSum + 8'd1;
      end
      if (minSum > 8'd99) begin
         quickSum = MAX_BCD;
      end else begin
         quickSum = {bin2bcd(minSum[6:0]), bin2bcd(secSum[6:0])};
      end
   end

   always_comb begin
      state_d = state_q;
      time_d  = time_q;
      if (state_q == ST_DONE) begin
         state_d = ST_IDLE;
      end else if (clear) begin
         state_d = ST_IDLE;
         time_d  = TIME_ZERO;
      end else if (door_open || pause) begin
         if (state_q == ST_RUN) state_d = ST_PAUSE;
      end else if (start) begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_RUN;
               if (time_q == TIME_ZERO) time_d = {8'h00, bin2bcd(7'(QUICK_SEC))};
            end
            ST_PAUSE: state_d = ST_RUN;
            ST_RUN:   time_d  = quickSum;
            default:  state_d = state_q;
         endcase
      end else if (load) begin
         if (state_q == ST_IDLE || state_q == ST_PAUSE) begin
            time_d = loadSan;
            if (loadSan == TIME_ZERO) state_d = ST_IDLE;
         end
      end else if (tick_1hz && state_q == ST_RUN) begin
         time_d = decResult;
         if (decZero) state_d = ST_DONE;
      end
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         time_q    <= TIME_ZERO;
         running_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         time_q    <= time_d;
         running_q <= (state_d == ST_RUN);
         done_q    <= (state_d == ST_DONE);
      end
   end

   assign time_bcd = time_q;
   assign running  = running_q;
   assign done     = done_q;

endmodule

// File: tb/tb_contador_regressivo.sv
// Self-checking bench for contador_regressivo: directed scenarios plus a
// randomized run, all checked against a seconds-based reference model.
module tb_contador_regressivo;

   localparam int QUICK   = 30;
   localparam int MAX_SEC = 99 * 60 + 59;

   logic        clk_in = 1'b0;
   logic        reset = 1'b1;
   logic        tick_1hz = 1'b0;
   logic        load = 1'b0;
   logic [15:0] load_bcd = 16'h0000;
   logic        start = 1'b0;
   logic        pause = 1'b0;
   logic        clear = 1'b0;
   logic        door_open = 1'b0;
   logic [15:0] time_bcd;
   logic        running;
   logic        done;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: total seconds and a mode (0 idle, 1 run, 2 pause, 3 done)
   int          m_secs = 0;
   int          m_mode = 0;
   logic [15:0] exp_time;
   logic        exp_running;
   logic        exp_done;

   contador_regressivo #(.QUICK_SEC(QUICK), .MAX_BCD(16'h9959)) dut (
      .clk_in    (clk_in),
      .reset     (reset),
      .tick_1hz  (tick_1hz),
      .load      (load),
      .load_bcd  (load_bcd),
      .start     (start),
      .pause     (pause),
      .clear     (clear),
      .door_open (door_open),
      .time_bcd  (time_bcd),
      .running   (running),
      .done      (done)
   );

   always #5 clk_in = ~clk_in;

   function automatic int bcd_to_secs(input logic [15:0] v);
      int d3, d2, d1, d0;
      d3 = (v[15:12] > 9) ? 9 : int'(v[15:12]);
      d2 = (v[11:8]  > 9) ? 9 : int'(v[11:8]);
      d1 = (v[7:4]   > 5) ? 5 : int'(v[7:4]);
      d0 = (v[3:0]   > 9) ? 9 : int'(v[3:0]);
      return (d3 * 10 + d2) * 60 + d1 * 10 + d0;
   endfunction

   function automatic logic [15:0] secs_to_bcd(input int s);
      int m, ss;
      m  = s / 60;
      ss = s % 60;
      return {4'(m / 10), 4'(m % 10), 4'(ss / 10), 4'(ss % 10)};
   endfunction

   // Advance one clock: the model consumes the inputs present before the edge
   task automatic step();
      int nm, ns;
      nm = m_mode;
      ns = m_secs;
      if (reset) begin
         nm = 0; ns = 0;
      end else if (m_mode == 3) begin
         nm = 0;
      end else if (clear) begin
         nm = 0; ns = 0;
      end else if (door_open || pause) begin
         if (m_mode == 1) nm = 2;
      end else if (start) begin
         if (m_mode == 0) begin
            if (ns == 0) ns = QUICK;
            nm = 1;
         end else if (m_mode == 2) begin
            nm = 1;
         end else if (m_mode == 1) begin
            ns = (m_secs + QUICK > MAX_SEC) ? MAX_SEC : m_secs + QUICK;
         end
      end else if (load) begin
         if (m_mode == 0 || m_mode == 2) begin
            ns = bcd_to_secs(load_bcd);
            if (ns == 0) nm = 0;
         end
      end else if (tick_1hz && m_mode == 1) begin
         ns = m_secs - 1;
         if (ns == 0) nm = 3;
      end
      @(posedge clk_in);
      #1;
      m_mode      = nm;
      m_secs      = ns;
      exp_time    = secs_to_bcd(m_secs);
      exp_running = (m_mode == 1);
      exp_done    = (m_mode == 3);
   endtask

   task automatic idle_inputs();
      tick_1hz = 0; load = 0; start = 0; pause = 0; clear = 0; door_open = 0;
   endtask

   task automatic test_reset();
      reset = 1;
      idle_inputs();
      step();
      reset = 0;
      n_checks++;
      if (time_bcd !== 16'h0000 || running !== 1'b0 || done !== 1'b0) begin
         n_errors++;
         $display("[TB] FAIL reset: time=%h running=%b done=%b, want 0000/0/0", time_bcd, running, done);
      end
   endtask

   task automatic test_countdown();
      logic [15:0] want [3];
      want[0] = 16'h0002; want[1] = 16'h0001; want[2] = 16'h0000;
      load = 1; load_bcd = 16'h0003; step(); load = 0;
      start = 1; step(); start = 0;
      n_checks++;
      if (running !== 1'b1 || time_bcd !== 16'h0003) begin
         n_errors++;
         $display("[TB] FAIL countdown_start: time=%h running=%b, want 0003/1", time_bcd, running);
      end
      for (int i = 0; i < 3; i++) begin
         tick_1hz = 1; step(); tick_1hz = 0;
         n_checks++;
         if (time_bcd !== want[i] || done !== (i == 2)) begin
            n_errors++;
            $display("[TB] FAIL countdown_tick%0d: time=%h done=%b, want %h/%b", i, time_bcd, done, want[i], (i == 2));
         end
      end
      step();
      n_checks++;
      if (done !== 1'b0 || running !== 1'b0 || time_bcd !== exp_time) begin
         n_errors++;
         $display("[TB] FAIL countdown_after_done: done=%b running=%b time=%h, want 0/0/%h", done, running, time_bcd, exp_time);
      end
   endtask

   task automatic test_load_sanitise();
      load = 1; load_bcd = 16'h1000; step(); load = 0;
      start = 1; step(); start = 0;
      tick_1hz = 1; step(); tick_1hz = 0;
      n_checks++;
      if (time_bcd !== 16'h0959) begin
         n_errors++;
         $display("[TB] FAIL borrow_1000: time=%h, want 0959", time_bcd);
      end
      clear = 1; step(); clear = 0;
      load = 1; load_bcd = 16'h1A7C; step(); load = 0;
      n_checks++;
      if (time_bcd !== 16'h1959 || running !== 1'b0) begin
         n_errors++;
         $display("[TB] FAIL sanitise_1A7C: time=%h running=%b, want 1959/0", time_bcd, running);
      end
   endtask

   task automatic test_door();
      clear = 1; step(); clear = 0;
      load = 1; load_bcd = 16'h0045; step(); load = 0;
      start = 1; step(); start = 0;
      door_open = 1; tick_1hz = 1; step(); tick_1hz = 0;
      n_checks++;
      if (time_bcd !== 16'h0045 || running !== 1'b0) begin
         n_errors++;
         $display("[TB] FAIL door_pause: time=%h running=%b, want 0045/0", time_bcd, running);
      end
      start = 1; step();
      n_checks++;
      if (running !== 1'b0) begin
         n_errors++;
         $display("[TB] FAIL door_start_blocked: running=%b, want 0", running);
      end
      door_open = 0; step(); start = 0;
      n_checks++;
      if (running !== 1'b1 || time_bcd !== 16'h0045) begin
         n_errors++;
         $display("[TB] FAIL door_resume: time=%h running=%b, want 0045/1", time_bcd, running);
      end
   endtask

   task automatic test_quick_start();
      clear = 1; step(); clear = 0;
      start = 1; step();
      n_checks++;
      if (time_bcd !== 16'h0030 || running !== 1'b1) begin
         n_errors++;
         $display("[TB] FAIL quick_zero: time=%h running=%b, want 0030/1", time_bcd, running);
      end
      step(); start = 0;
      n_checks++;
      if (time_bcd !== 16'h0100) begin
         n_errors++;
         $display("[TB] FAIL quick_add: time=%h, want 0100", time_bcd);
      end
      clear = 1; step(); clear = 0;
      load = 1; load_bcd = 16'h9945; step(); load = 0;
      start = 1; step(); step(); start = 0;
      n_checks++;
      if (time_bcd !== 16'h9959 || running !== 1'b1) begin
         n_errors++;
         $display("[TB] FAIL quick_saturate: time=%h running=%b, want 9959/1", time_bcd, running);
      end
   endtask

   task automatic test_clear();
      clear = 1; start = 1; tick_1hz = 1; step();
      clear = 0; start = 0; tick_1hz = 0;
      n_checks++;
      if (time_bcd !== 16'h0000 || running !== 1'b0 || done !== 1'b0) begin
         n_errors++;
         $display("[TB] FAIL clear_priority: time=%h running=%b done=%b, want 0000/0/0", time_bcd, running, done);
      end
   endtask

   task automatic test_reset_mid_run();
      load = 1; load_bcd = 16'h0512; step(); load = 0;
      start = 1; step(); start = 0;
      reset = 1; step(); reset = 0;
      n_checks++;
      if (time_bcd !== 16'h0000 || running !== 1'b0) begin
         n_errors++;
         $display("[TB] FAIL reset_mid_run: time=%h running=%b, want 0000/0", time_bcd, running);
      end
      tick_1hz = 1; step(); step(); step(); tick_1hz = 0;
      n_checks++;
      if (time_bcd !== 16'h0000 || running !== 1'b0) begin
         n_errors++;
         $display("[TB] FAIL ticks_after_reset: time=%h running=%b, want 0000/0", time_bcd, running);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         reset     = ($urandom_range(99) == 0);
         clear     = ($urandom_range(39) == 0);
         pause     = ($urandom_range(19) == 0);
         start     = ($urandom_range(7) == 0);
         load      = ($urandom_range(5) == 0);
         load_bcd  = ($urandom_range(3) == 0) ? 16'($urandom) : 16'($urandom_range(16'h0130));
         tick_1hz  = ($urandom_range(1) == 0);
         if ($urandom_range(15) == 0) door_open = ~door_open;
         step();
         n_checks++;
         if (time_bcd !== exp_time || running !== exp_running || done !== exp_done) begin
            n_errors++;
            $display("[TB] FAIL random_cycle%0d: time=%h running=%b done=%b, want %h/%b/%b",
                     i, time_bcd, running, done, exp_time, exp_running, exp_done);
         end
      end
      idle_inputs();
      reset = 0;
   endtask

   initial begin
      test_reset();
      test_countdown();
      test_load_sanitise();
      test_door();
      test_quick_start();
      test_clear();
      test_reset_mid_run();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/contador_regressivo.md
Name: contador_regressivo

Overview:
- Cooking countdown timer for the microwave, holding minutes and seconds in BCD (MM:SS).
- Sits directly downstream of the 100 Hz to 1 Hz divider: consumes its 1 Hz output as a one-cycle enable (tick_1hz), not as a clock.
- Takes a time setting loaded from the keypad encoder, counts down to 00:00 while running and signals completion.
- Drives the running indication used by the magnetron/lamp control and the display path.

Parameters:
QUICK_SEC, 30, seconds added by start in IDLE-with-zero or in RUN; legal range 1..59
MAX_BCD, 16'h9959, saturation ceiling for time_bcd (99:59)

Ports:
clk_in  input  1  system clock, 100 Hz; all logic on rising edge
reset  input  1  synchronous, active-high; one clock, no other clock or async reset
tick_1hz  input  1  one-cycle enable pulse, one per second, synchronous to clk_in
load  input  1  load load_bcd into the timer
load_bcd  input  16  {min_tens, min_units, sec_tens, sec_units}, BCD
start  input  1  start/resume, or +QUICK_SEC
pause  input  1  pause request
clear  input  1  abort, zero the time
door_open  input  1  level; forces pause while high
time_bcd  output  16  current MM:SS in BCD, registered
running  output  1  high in RUN, registered
done  output  1  one-cycle pulse on reaching 00:00

Behaviour:
- Reset (sync): state=IDLE, time_bcd=16'h0000, running=0, done=0.
- States: IDLE, RUN, PAUSE, DONE. Encoding is 2 bits. running is high only in RUN.
- Per-cycle priority: reset > clear > door_open > pause > start > load > tick_1hz.
- clear, any state: go to IDLE and set time=0000 on the next edge.
- load, accepted only in IDLE or PAUSE; ignored in RUN and DONE:
  - time is set on the next edge.
  - Digits are sanitised: any digit >9 becomes 9; sec_tens >5 becomes 5. Example: 16'h1A7C becomes 16'h1959.
  - load in PAUSE with a zero value sets time=0000 and moves the state to IDLE.
- start:
  - IDLE, time!=0, door_open=0: go to RUN.
  - IDLE, time=0, door_open=0: set time=QUICK_SEC as 00:SS BCD and go to RUN in the same edge.
  - PAUSE, door_open=0: go to RUN; time is always nonzero in PAUSE.
  - RUN: time += QUICK_SEC as a BCD add with seconds carrying into minutes; saturate at MAX_BCD. Any tick in that cycle is dropped.
  - Ignored in DONE and whenever door_open=1.
- pause or door_open in RUN: go to PAUSE; any tick in that cycle is dropped. door_open in IDLE/PAUSE: no state change.
- tick_1hz in RUN with no higher-priority event: decrement with BCD borrow. sec_units 0 to 9 borrows from sec_tens; sec_tens 0 to 5 borrows from min_units; min_units 0 to 9 borrows from min_tens.
  - Example: 10:00 becomes 09:59.
  - time_bcd shows the new value one cycle after the tick edge.
- Decrement from 00:01 to 00:00: time=0000 and state=DONE on the same edge. done=1 for exactly that cycle. DONE goes to IDLE on the next edge unconditionally, apart from reset.
- tick_1hz outside RUN is ignored. Back-to-back ticks on consecutive cycles each decrement; this is legal for test acceleration.
- RUN is never held at time=0000.

Decomposition:
- Shared package (contador_pkg):
  - state encodings ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE
  - BCD_MAX_DIGIT=9, BCD_MAX_SEC_TENS=5, TIME_ZERO=16'h0000
- Sub-module bcd_mmss_dec: combinational MM:SS BCD decrement-by-one. Inputs 16-bit time, outputs 16-bit result plus a zero flag that is high when the result is 0000.
- The +QUICK_SEC adder and the load sanitiser stay inline.

Test Plan:
- reset, then load 16'h0003, start, 3 ticks -> time 0002, 0001, 0000; done high exactly 1 cycle on the 0000 edge; then IDLE, running=0.
- load 16'h1000, start, 1 tick -> time_bcd=16'h0959; load 16'h1A7C in IDLE -> 16'h1959.
- RUN at 0045, door_open=1 coincident with a tick -> PAUSE, time stays 0045. start while door_open=1 -> ignored. door_open=0 then start -> RUN.
- IDLE, time 0, start -> time=0030, RUN. start again -> 0100. At 9945, start -> 9959 (saturated).
- RUN, clear together with start and a tick -> IDLE, time=0000, running=0, no done.
- reset asserted mid-RUN at 0512 -> next edge time=0000, IDLE; subsequent ticks leave time at 0000.
